pc_fetch_ctrl: RTL and testbench

- Consumer side of the `next_pc_op` interface driven by the EX-stage branch resolver.
- Owns the architectural PC register and drives fetch requests to instruction memory over a req/ready handshake.
- Applies taken-branch and jump redirects, and generates the pipeline flushes for IF/ID and ID/EX.
- Sits at the front of the 5-stage pipeline, between the hazard unit, instruction memory and the IF/ID register.

---
 rtl/pc_fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch controller: sequential fetch over a req/ready handshake,
// EX-stage branch/jump redirects with IF/ID and ID/EX flushes. Optional: `PC_MISALIGN_TRAP_EN.
module pc_fetch_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [2:0]      next_pc_op,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc4,
  output logic            redirect,
  output logic            flush_if_id,
  output logic            flush_id_ex
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic            misalign_trap,
  output logic [XLEN-1:0] misalign_addr
`endif
);

  typedef enum logic [1:0] {
    RST_HOLD,
    FETCH,
    DISCARD,
    TRAP_IDLE
  } state_e;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] tgt;
  logic            active;
  logic            redir_req;
  logic            mis;

  always_comb begin
    jalr_sum = ex_rs1 + ex_imm;
    tgt      = (next_pc_op == 3'b011) ? {jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
  end

  assign active    = (state_q == FETCH) || (state_q == DISCARD);
  assign redir_req = active && ex_valid &&
                     ((next_pc_op == 3'b001) || (next_pc_op == 3'b010) || (next_pc_op == 3'b011));

`ifdef PC_MISALIGN_TRAP_EN
  assign mis = redir_req && tgt[1];
`else
  assign mis = 1'b0;
`endif

  // pc_q always holds the address on the bus, so an outstanding request keeps
  // its address stable; a redirect that cannot land yet parks in pend_q.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    unique case (state_q)
      RST_HOLD: state_d = FETCH;
      FETCH: begin
        if (redir_req) begin
          if (mis) begin
            state_d = TRAP_IDLE;
          end else if (imem_ready) begin
            pc_d = tgt;
          end else begin
            pend_d  = tgt;
            state_d = DISCARD;
          end
        end else if (imem_ready && !stall) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      DISCARD: begin
        if (mis) begin
          state_d = TRAP_IDLE;
        end else if (imem_ready) begin
          pc_d    = redir_req ? tgt : pend_q;
          state_d = FETCH;
        end else if (redir_req) begin
          pend_d = tgt;
        end
      end
      default: state_d = state_q;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic [XLEN-1:0] mis_addr_q;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RST_HOLD;
      pc_q    <= RESET_PC;
      pend_q  <= RESET_PC;
`ifdef PC_MISALIGN_TRAP_EN
      mis_addr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
`ifdef PC_MISALIGN_TRAP_EN
      if (mis) mis_addr_q <= tgt;
`endif
    end
  end

  assign imem_req    = active;
  assign imem_addr   = pc_q;
  assign if_valid    = (state_q == FETCH) && imem_ready && !stall && !redir_req;
  assign if_pc       = pc_q;
  assign if_pc4      = pc_q + PC_STEP;
  assign redirect    = redir_req && !mis;
  assign flush_if_id = redir_req;
  assign flush_id_ex = redir_req;

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_trap = mis;
  assign misalign_addr = mis ? tgt : mis_addr_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed vectors push expected IF/redirect events,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  next_pc_op;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_rs1;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        if_valid;
  logic [31:0] if_pc, if_pc4;
  logic        redirect, flush_if_id, flush_id_ex;
  logic        trap_w;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_trap;
  logic [31:0] misalign_addr;
  assign trap_w = misalign_trap;
`else
  assign trap_w = 1'b0;
`endif

  pc_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rstn(rstn), .next_pc_op(next_pc_op), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc4(if_pc4),
    .redirect(redirect), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex)
`ifdef PC_MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap), .misalign_addr(misalign_addr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_redir;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  localparam int NONE = 0;
  localparam int VAL  = 1;
  localparam int RED  = 2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted fetch or redirect must match the head of the scoreboard.
  always @(negedge clk) begin
    if (if_valid || redirect || ((flush_if_id || flush_id_ex) && !trap_w)) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {29'd0, if_valid, redirect, flush_if_id}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.is_redir) begin
          chk("redirect", {31'd0, redirect}, 32'd1);
          chk("flush_if_id", {31'd0, flush_if_id}, 32'd1);
          chk("flush_id_ex", {31'd0, flush_id_ex}, 32'd1);
          chk("if_valid_on_redirect", {31'd0, if_valid}, 32'd0);
        end else begin
          chk("if_valid", {31'd0, if_valid}, 32'd1);
          chk("if_pc", if_pc, e.pc);
          chk("if_pc4", if_pc4, e.pc4);
          chk("flush_on_fetch", {30'd0, flush_if_id, flush_id_ex}, 32'd0);
        end
      end
    end
  end

  task automatic cyc(input bit exv, input logic [2:0] op, input logic [31:0] pc,
                     input logic [31:0] imm, input logic [31:0] rs1, input bit st,
                     input bit rdy, input int kind, input logic [31:0] epc, input logic [31:0] epc4);
    exp_t e;
    ex_valid   = exv;
    next_pc_op = op;
    ex_pc      = pc;
    ex_imm     = imm;
    ex_rs1     = rs1;
    stall      = st;
    imem_ready = rdy;
    if (kind != NONE) begin
      e.is_redir = (kind == RED);
      e.pc       = epc;
      e.pc4      = epc4;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic seq(input bit rdy, input logic [31:0] epc, input logic [31:0] epc4);
    cyc(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, rdy, VAL, epc, epc4);
  endtask

  task automatic jal(input logic [31:0] pc, input logic [31:0] imm, input bit st, input bit rdy);
    cyc(1'b1, 3'b010, pc, imm, 32'h0, st, rdy, RED, 32'h0, 32'h0);
  endtask

  task automatic idle(input bit st, input bit rdy);
    cyc(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, st, rdy, NONE, 32'h0, 32'h0);
  endtask

  initial begin
    rstn = 1'b0; ex_valid = 1'b0; next_pc_op = 3'b000; ex_pc = '0; ex_imm = '0;
    ex_rs1 = '0; stall = 1'b0; imem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_pc4", if_pc4, 32'h4);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_flush", {29'd0, redirect, flush_if_id, flush_id_ex}, 32'd0);
    rstn = 1'b1;
    #1;
    chk("hold_cycle_no_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    // sequential fetch
    seq(1'b1, 32'h0, 32'h4);
    seq(1'b1, 32'h4, 32'h8);
    seq(1'b1, 32'h8, 32'hC);

    // taken branch with negative offset: 0x100 - 0x10
    cyc(1'b1, 3'b001, 32'h100, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b1, RED, 32'h0, 32'h0);
    chk("branch_addr", imem_addr, 32'hF0);
    seq(1'b1, 32'hF0, 32'hF4);
    seq(1'b1, 32'hF4, 32'hF8);

    // JALR: (0x2001 + 4) & ~1
    cyc(1'b1, 3'b011, 32'h0, 32'h4, 32'h2001, 1'b0, 1'b1, RED, 32'h0, 32'h0);
    seq(1'b1, 32'h2004, 32'h2008);
    // reserved ops and ex_valid=0 are ignored
    cyc(1'b1, 3'b100, 32'h500, 32'h4, 32'h0, 1'b0, 1'b1, VAL, 32'h2008, 32'h200C);
    cyc(1'b1, 3'b111, 32'h500, 32'h4, 32'h0, 1'b0, 1'b1, VAL, 32'h200C, 32'h2010);
    cyc(1'b0, 3'b010, 32'h500, 32'h4, 32'h0, 1'b0, 1'b1, VAL, 32'h2010, 32'h2014);

    // outstanding request at 0x40, JAL to 0x80 while ready is low
    jal(32'h30, 32'h10, 1'b0, 1'b1);
    chk("jal40_addr", imem_addr, 32'h40);
    jal(32'h70, 32'h10, 1'b0, 1'b0);
    chk("discard_addr_hold1", imem_addr, 32'h40);
    chk("discard_req", {31'd0, imem_req}, 32'd1);
    idle(1'b0, 1'b0);
    chk("discard_addr_hold2", imem_addr, 32'h40);
    idle(1'b0, 1'b0);
    chk("discard_addr_hold3", imem_addr, 32'h40);
    idle(1'b0, 1'b1);
    chk("after_discard_addr", imem_addr, 32'h80);
    seq(1'b1, 32'h80, 32'h84);

    // stall holds pc; a JAL during the stall still redirects
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    chk("stall_addr_hold", imem_addr, 32'h84);
    jal(32'h200, 32'h20, 1'b1, 1'b1);
    seq(1'b1, 32'h220, 32'h224);

    // two redirects while discarding: youngest wins
    jal(32'h300, 32'h0, 1'b0, 1'b0);
    jal(32'h400, 32'h4, 1'b0, 1'b0);
    chk("youngest_hold_addr", imem_addr, 32'h224);
    idle(1'b0, 1'b1);
    seq(1'b1, 32'h404, 32'h408);

    // wrap-around target
    jal(32'hFFFF_FFF0, 32'h20, 1'b0, 1'b1);
    seq(1'b1, 32'h10, 32'h14);

    // reset mid-discard
    jal(32'h500, 32'h0, 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_redirect", {31'd0, redirect}, 32'd0);
    idle(1'b0, 1'b1);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    seq(1'b1, 32'h0, 32'h4);
    seq(1'b1, 32'h4, 32'h8);

`ifdef PC_MISALIGN_TRAP_EN
    ex_valid = 1'b1; next_pc_op = 3'b010; ex_pc = 32'h100; ex_imm = 32'h2;
    stall = 1'b0; imem_ready = 1'b1;
    #1;
    chk("trap_pulse", {31'd0, misalign_trap}, 32'd1);
    chk("trap_addr", misalign_addr, 32'h102);
    chk("trap_flush", {31'd0, flush_if_id}, 32'd1);
    @(posedge clk);
    #1;
    idle(1'b0, 1'b1);
    chk("trap_one_cycle", {31'd0, misalign_trap}, 32'd0);
    chk("trap_idle_req", {31'd0, imem_req}, 32'd0);
    idle(1'b0, 1'b1);
    chk("trap_idle_req2", {31'd0, imem_req}, 32'd0);
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("trap_reset_req", {31'd0, imem_req}, 32'd1);
`endif

    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
